// File: rtl/iter_div_if.sv
// Operand/result stream bundle for iter_div. The divider sits on the slave modport;
// dbg_state mirrors the divider FSM state for observation.
interface iter_div_if;
    logic [31:0] s_axis_dividend_tdata;
    logic        s_axis_dividend_tvalid;
    logic        s_axis_dividend_tready;
    logic [31:0] s_axis_divisor_tdata;
    logic        s_axis_divisor_tvalid;
    logic        s_axis_divisor_tready;
    logic [63:0] m_axis_dout_tdata;
    logic        m_axis_dout_tuser;
    logic        m_axis_dout_tvalid;
    logic [1:0]  dbg_state;

    // Handshake: an operation is taken on a rising edge where both tvalids and tready
    // are high; the result tvalid is a one-cycle pulse with no back-pressure.
    modport slave (
        input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
        input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
        output s_axis_dividend_tready, s_axis_divisor_tready,
        output m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid,
        output dbg_state
    );

    modport master (
        output s_axis_dividend_tdata, s_axis_dividend_tvalid,
        output s_axis_divisor_tdata, s_axis_divisor_tvalid,
        input  s_axis_dividend_tready, s_axis_divisor_tready,
        input  m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid,
        input  dbg_state
    );
endinterface

// File: rtl/iter_div.sv
// 32/32 iterative radix-2 restoring divider, signed or unsigned, 32-cycle latency.
// Result is {quotient, remainder}; tuser flags divide-by-zero.
module iter_div #(
    parameter int SIGNED = 1
) (
    input  logic      clk,
    input  logic      resetn,
    iter_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic [63:0] tdata_q, tdata_d;
    logic        tuser_q, tuser_d;
    logic        tvalid_q, tvalid_d;

    logic        ready, fire;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted, trial;
    logic        step_ok;
    logic [31:0] step_quo, step_rem;
    logic [31:0] q_fix, r_fix;

    assign ready = resetn && (state_q != CALC);
    assign fire  = ready && bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid;

    assign a_neg = (SIGNED != 0) && bus.s_axis_dividend_tdata[31];
    assign b_neg = (SIGNED != 0) && bus.s_axis_divisor_tdata[31];
    assign a_mag = a_neg ? (~bus.s_axis_dividend_tdata + 32'd1) : bus.s_axis_dividend_tdata;
    assign b_mag = b_neg ? (~bus.s_axis_divisor_tdata + 32'd1) : bus.s_axis_divisor_tdata;

    // One restoring step: the dividend magnitude shifts out of quo_q into the partial remainder.
    assign shifted  = {rem_q, quo_q[31]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign step_ok  = (shifted >= {1'b0, dvs_q});
    assign step_rem = step_ok ? trial[31:0] : shifted[31:0];
    assign step_quo = {quo_q[30:0], step_ok};

    // With a zero divisor every step succeeds, so the remainder path rebuilds the raw dividend.
    assign q_fix = dz_q ? 32'hFFFF_FFFF : (qneg_q ? (~step_quo + 32'd1) : step_quo);
    assign r_fix = rneg_q ? (~step_rem + 32'd1) : step_rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tvalid_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (fire) begin
                    state_d = CALC;
                    cnt_d   = 5'd0;
                    quo_d   = a_mag;
                    rem_d   = 32'd0;
                    dvs_d   = b_mag;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dz_d    = (bus.s_axis_divisor_tdata == 32'd0);
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = DONE;
                    tdata_d  = {q_fix, r_fix};
                    tuser_d  = dz_q;
                    tvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            tdata_q  <= 64'd0;
            tuser_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign bus.s_axis_dividend_tready = ready;
    assign bus.s_axis_divisor_tready  = ready;
    assign bus.m_axis_dout_tdata      = tdata_q;
    assign bus.m_axis_dout_tuser      = tuser_q;
    assign bus.m_axis_dout_tvalid     = tvalid_q;
    assign bus.dbg_state              = state_q;
endmodule

// File: tb/tb_iter_div.sv
// Bench for iter_div: one unsigned and one signed instance, directed and random divides,
// results checked against an expected queue with per-result latency.
module tb_iter_div;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_div_if bus_u ();
    iter_div_if bus_s ();

    iter_div #(.SIGNED(0)) u_dut_u (.clk(clk), .resetn(resetn), .bus(bus_u));
    iter_div #(.SIGNED(1)) u_dut_s (.clk(clk), .resetn(resetn), .bus(bus_s));

    logic [31:0] a_u = '0, b_u = '0, a_s = '0, b_s = '0;
    logic        av_u = 1'b0, bv_u = 1'b0, av_s = 1'b0, bv_s = 1'b0;

    assign bus_u.s_axis_dividend_tdata  = a_u;
    assign bus_u.s_axis_dividend_tvalid = av_u;
    assign bus_u.s_axis_divisor_tdata   = b_u;
    assign bus_u.s_axis_divisor_tvalid  = bv_u;
    assign bus_s.s_axis_dividend_tdata  = a_s;
    assign bus_s.s_axis_dividend_tvalid = av_s;
    assign bus_s.s_axis_divisor_tdata   = b_s;
    assign bus_s.s_axis_divisor_tvalid  = bv_s;

    logic [64:0] exp_u_q[$];
    logic [64:0] exp_s_q[$];
    int          cyc_u_q[$];
    int          cyc_s_q[$];
    logic [64:0] last_u = '0, last_s = '0;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus_s.s_axis_dividend_tready : bus_u.s_axis_dividend_tready;
    endfunction

    function automatic logic [64:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (!sgn) return {1'b0, a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'h0};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(q), 32'(r)};
    endfunction

    task automatic drive(input bit sel, input logic av, input logic bv,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            av_s = av; bv_s = bv; a_s = a; b_s = b;
        end else begin
            av_u = av; bv_u = bv; a_u = a; b_u = b;
        end
    endtask

    task automatic push_exp(input bit sel, input logic [64:0] exp, input int hs_cyc);
        if (sel) begin
            exp_s_q.push_back(exp); cyc_s_q.push_back(hs_cyc + 32); last_s = exp;
        end else begin
            exp_u_q.push_back(exp); cyc_u_q.push_back(hs_cyc + 32); last_u = exp;
        end
    endtask

    // Waits for tready, performs one handshake, then scrambles the idle operand lines.
    task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [64:0] exp, input bit push);
        @(negedge clk);
        for (int k = 0; k < 100 && !rdy(sel); k++) @(negedge clk);
        check(sel ? "s_ready_wait" : "u_ready_wait", 65'(rdy(sel)), 65'd1);
        drive(sel, 1'b1, 1'b1, a, b);
        @(posedge clk);
        #1;
        if (push) push_exp(sel, exp, cyc);
        drive(sel, 1'b0, 1'b0, $urandom, $urandom);
        if (sel)
            check("s_ready_low_calc", 65'({bus_s.s_axis_dividend_tready, bus_s.s_axis_divisor_tready}), 65'd0);
        else
            check("u_ready_low_calc", 65'({bus_u.s_axis_dividend_tready, bus_u.s_axis_divisor_tready}), 65'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (exp_u_q.size() != 0 || exp_s_q.size() != 0); k++) @(negedge clk);
        check("drain_pending", 65'(exp_u_q.size() + exp_s_q.size()), 65'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus_u.m_axis_dout_tvalid) begin
            n_cmp++;
            assert (exp_u_q.size() != 0) else begin
                n_fail++;
                $error("FAIL u_unexpected_tvalid: observed tvalid 1 at cycle %0d expected no pulse", cyc);
            end
            if (exp_u_q.size() != 0) begin
                check("u_result", {bus_u.m_axis_dout_tuser, bus_u.m_axis_dout_tdata}, exp_u_q.pop_front());
                check("u_latency", 65'(cyc), 65'(cyc_u_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (bus_s.m_axis_dout_tvalid) begin
            n_cmp++;
            assert (exp_s_q.size() != 0) else begin
                n_fail++;
                $error("FAIL s_unexpected_tvalid: observed tvalid 1 at cycle %0d expected no pulse", cyc);
            end
            if (exp_s_q.size() != 0) begin
                check("s_result", {bus_s.m_axis_dout_tuser, bus_s.m_axis_dout_tdata}, exp_s_q.pop_front());
                check("s_latency", 65'(cyc), 65'(cyc_s_q.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_u_outputs", {bus_u.s_axis_dividend_tready, bus_u.m_axis_dout_tvalid,
                                bus_u.m_axis_dout_tuser, bus_u.m_axis_dout_tdata[61:0]}, 65'd0);
        check("rst_s_outputs", {bus_s.s_axis_divisor_tready, bus_s.m_axis_dout_tvalid,
                                bus_s.m_axis_dout_tuser, bus_s.m_axis_dout_tdata[61:0]}, 65'd0);
        resetn = 1'b1;
        #1;
        check("rst_release_ready", 65'({rdy(1'b0), rdy(1'b1)}), 65'd3);

        // Directed divides
        do_op(1'b0, 32'd100, 32'd7, {1'b0, 64'h0000000E_00000002}, 1'b1);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, {1'b0, 64'hFFFFFFFD_FFFFFFFF}, 1'b1);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, {1'b0, 64'hFFFFFFFD_00000001}, 1'b1);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 64'h80000000_00000000}, 1'b1);
        do_op(1'b1, 32'd5, 32'd0, {1'b1, 64'hFFFFFFFF_00000005}, 1'b1);
        do_op(1'b1, 32'hFFFF_FFFB, 32'd0, {1'b1, 64'hFFFFFFFF_FFFFFFFB}, 1'b1);
        do_op(1'b0, 32'h1234_5678, 32'd0, {1'b1, 64'hFFFFFFFF_12345678}, 1'b1);

        // Dividend valid alone must not be consumed
        @(negedge clk);
        for (int k = 0; k < 100 && !rdy(1'b0); k++) @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd1000, 32'd9);
        repeat (3) @(posedge clk);
        #1;
        check("u_dividend_alone_ready", 65'(rdy(1'b0)), 65'd1);
        @(negedge clk);
        bv_u = 1'b1;
        @(posedge clk);
        #1;
        push_exp(1'b0, {1'b0, 64'h0000006F_00000001}, cyc);
        drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
        drain();

        // Reset at iteration 10 abandons the operation
        do_op(1'b0, 32'd77, 32'd3, 65'd0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("u_reset_mid_calc", {bus_u.s_axis_dividend_tready, bus_u.m_axis_dout_tvalid,
                                   bus_u.m_axis_dout_tuser, bus_u.m_axis_dout_tdata[61:0]}, 65'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("u_ready_after_reset", 65'(rdy(1'b0)), 65'd1);
        repeat (40) @(negedge clk);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h10, {1'b0, 64'h0FFFFFFF_0000000F}, 1'b1);

        // Back-to-back: the second handshake lands in the DONE cycle of the first
        do_op(1'b0, 32'hDEAD_BEEF, 32'h1234, model(1'b0, 32'hDEAD_BEEF, 32'h1234), 1'b1);
        do_op(1'b0, 32'd50, 32'd3, model(1'b0, 32'd50, 32'd3), 1'b1);

        // Random operands on both instances
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            do_op(i[0], ra, rb, model(i[0], ra, rb), 1'b1);
        end
        drain();

        // Result registers hold after the pulse
        repeat (3) @(negedge clk);
        check("u_hold", {bus_u.m_axis_dout_tuser, bus_u.m_axis_dout_tdata}, last_u);
        check("s_hold", {bus_s.m_axis_dout_tuser, bus_s.m_axis_dout_tdata}, last_s);
        check("idle_tvalid", 65'({bus_u.m_axis_dout_tvalid, bus_s.m_axis_dout_tvalid}), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
